// File: rtl/mpu_pkg.sv
// Shared types for the matrix-unit scratchpad read path: stream beat and
// tile-reader FSM state encoding.
package mpu_pkg;

  localparam int SPAD_ADDR_W = 16;
  localparam int SPAD_DATA_W = 8;
  localparam int SPAD_DIM_W  = 8;

  // One byte of the operand stream plus its row/tile boundary tags.
  typedef struct packed {
    logic [SPAD_DATA_W-1:0] data;
    logic                   eol;
    logic                   last;
  } beat_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/spad_rd_fifo2.sv
// Two-entry FIFO that absorbs scratchpad read returns while the stream
// consumer is stalled; push and pop may occur in the same cycle.
module spad_rd_fifo2
  import mpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  beat_t      i_push_beat,
  input  logic       i_pop,
  output logic [1:0] o_count,
  output beat_t      o_head
);

  beat_t      r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  // NOTE: the storage is reset along with the pointers so the head reads
  // as zero after reset and no byte from an aborted tile can resurface.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_beat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/spad_tile_reader.sv
// Scratchpad tile reader: walks a 2-D tile (base/rows/cols/stride), issues
// 1-cycle-latency reads and streams the bytes row-major with eol/last tags.
module spad_tile_reader
  import mpu_pkg::*;
#(
  parameter int ADDR_W = SPAD_ADDR_W,
  parameter int DATA_W = SPAD_DATA_W,
  parameter int DIM_W  = SPAD_DIM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [DIM_W-1:0]  cmd_rows,
  input  logic [DIM_W-1:0]  cmd_cols,
  input  logic [ADDR_W-1:0] cmd_stride,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_eol,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  rd_state_t         r_state;
  rd_state_t         w_state_nxt;

  logic [DIM_W-1:0]  r_rows;
  logic [DIM_W-1:0]  r_cols;
  logic [DIM_W-1:0]  r_row;
  logic [DIM_W-1:0]  r_col;
  logic [ADDR_W-1:0] r_stride;
  logic [ADDR_W-1:0] r_row_ptr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_inflight;
  logic              r_infl_eol;
  logic              r_infl_last;
  logic              r_cmd_ready;
  logic              r_done;

  logic              w_accept;
  logic              w_zero_dim;
  logic              w_col_end;
  logic              w_row_end;
  logic              w_pop;
  logic              w_has_slot;
  logic              w_issue;
  logic              w_done_nxt;
  logic [2:0]        w_occ;
  logic [2:0]        w_slots;
  logic [1:0]        w_count;
  logic [ADDR_W-1:0] w_issue_addr;
  beat_t             w_push_beat;
  beat_t             w_head;

  assign w_accept     = cmd_valid & r_cmd_ready;
  assign w_zero_dim   = (cmd_rows == '0) || (cmd_cols == '0);
  assign w_col_end    = (r_col == r_cols - DIM_W'(1));
  assign w_row_end    = (r_row == r_rows - DIM_W'(1));
  assign w_issue_addr = r_row_ptr + ADDR_W'(r_col);
  assign w_pop        = out_valid & out_ready;

  // Outstanding bytes (buffered + in flight) after this cycle's pop must
  // leave room for one more, which keeps the 2-entry FIFO from overflowing.
  assign w_occ      = {1'b0, w_count} + {2'b00, r_inflight};
  assign w_slots    = 3'd2 + {2'b00, w_pop};
  assign w_has_slot = (w_occ < w_slots);

  // NOTE: every signal written here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_zero_dim) w_done_nxt  = 1'b1;
          else            w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_issue = w_has_slot;
        if (w_has_slot && w_col_end && w_row_end) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The tagged last byte is the only one left once it handshakes.
        if (w_pop && w_head.last) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rows      <= '0;
      r_cols      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_stride    <= '0;
      r_row_ptr   <= '0;
      r_mem_addr  <= '0;
      r_inflight  <= 1'b0;
      r_infl_eol  <= 1'b0;
      r_infl_last <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // cmd_ready is registered so it stays low while reset is held.
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_done      <= w_done_nxt;
      r_inflight  <= w_issue;
      r_infl_eol  <= w_col_end;
      r_infl_last <= w_col_end & w_row_end;
      if (w_accept) begin
        r_rows    <= cmd_rows;
        r_cols    <= cmd_cols;
        r_stride  <= cmd_stride;
        r_row_ptr <= cmd_base;
        r_row     <= '0;
        r_col     <= '0;
      end else if (w_issue) begin
        r_mem_addr <= w_issue_addr;
        if (w_col_end) begin
          r_col     <= '0;
          r_row     <= r_row + DIM_W'(1);
          r_row_ptr <= r_row_ptr + r_stride;
        end else begin
          r_col <= r_col + DIM_W'(1);
        end
      end
    end
  end

  assign w_push_beat.data = mem_rdata;
  assign w_push_beat.eol  = r_infl_eol;
  assign w_push_beat.last = r_infl_last;

  spad_rd_fifo2 u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .i_push      (r_inflight),
    .i_push_beat (w_push_beat),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  // The address is presented combinationally in the issue cycle so the
  // scratchpad samples it at that edge; otherwise it holds the last read.
  assign mem_addr  = w_issue ? w_issue_addr : r_mem_addr;
  assign mem_wen   = 1'b0;
  assign cmd_ready = r_cmd_ready;
  assign out_valid = (w_count != 2'd0);
  assign out_data  = w_head.data;
  assign out_eol   = w_head.eol;
  assign out_last  = w_head.last;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_spad_tile_reader.sv
// Self-checking bench for spad_tile_reader: scratchpad model plus a
// scoreboard of expected stream beats filled when each command is driven.
module tb_spad_tile_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_base = '0;
  logic [7:0]  cmd_rows = '0;
  logic [7:0]  cmd_cols = '0;
  logic [15:0] cmd_stride = '0;
  logic [15:0] mem_addr;
  logic        mem_wen;
  logic [7:0]  mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_eol;
  logic        out_last;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  spad_tile_reader dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_base   (cmd_base),
    .cmd_rows   (cmd_rows),
    .cmd_cols   (cmd_cols),
    .cmd_stride (cmd_stride),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_eol    (out_eol),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  // Scratchpad: 1-cycle synchronous read, registered dout.
  logic [7:0] smem [0:65535];
  always @(posedge clk) mem_rdata <= smem[mem_addr];

  typedef struct {
    logic [7:0] data;
    logic       eol;
    logic       last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   wen_hits = 0;
  logic prev_stall = 1'b0;
  logic [9:0] prev_payload = '0;

  // Stream monitor: pops the scoreboard on every handshake and checks that
  // a stalled beat stays put.
  always @(negedge clk) begin
    if (mem_wen !== 1'b0) wen_hits++;
    if (rst) begin
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || {out_data, out_eol, out_last} !== prev_payload) begin
          bad++;
          $display("FAIL stall_stable: got valid=%b payload=%h want valid=1 payload=%h",
                   out_valid, {out_data, out_eol, out_last}, prev_payload);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_byte: got data=%h eol=%b last=%b want no byte",
                   out_data, out_eol, out_last);
        end else begin
          mon_e = sb.pop_front();
          if (out_data !== mon_e.data || out_eol !== mon_e.eol || out_last !== mon_e.last) begin
            bad++;
            $display("FAIL stream_beat: got data=%h eol=%b last=%b want data=%h eol=%b last=%b",
                     out_data, out_eol, out_last, mon_e.data, mon_e.eol, mon_e.last);
          end
        end
      end
      prev_stall   = out_valid && !out_ready;
      prev_payload = {out_data, out_eol, out_last};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_tile(input logic [15:0] base, input int rows, input int cols,
                           input logic [15:0] stride);
    exp_t e;
    logic [15:0] a;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        a = base + 16'(r) * stride + 16'(c);
        e.data = smem[a];
        e.eol  = (c == cols - 1);
        e.last = (c == cols - 1) && (r == rows - 1);
        sb.push_back(e);
      end
    end
  endtask

  // Returns #1 after the accepting posedge.
  task automatic send_cmd(input logic [15:0] base, input int rows, input int cols,
                          input logic [15:0] stride);
    int n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL cmd_ready_wait: got cmd_ready=%b want 1", cmd_ready);
    end
    cmd_base   = base;
    cmd_rows   = 8'(rows);
    cmd_cols   = 8'(cols);
    cmd_stride = stride;
    cmd_valid  = 1'b1;
    push_tile(base, rows, cols, stride);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready);
    end
    total++;
    if ({busy, done, out_valid, out_eol, out_last, mem_wen, mem_addr, out_data} !== 30'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b valid=%b eol=%b last=%b wen=%b addr=%h data=%h want all 0",
               busy, done, out_valid, out_eol, out_last, mem_wen, mem_addr, out_data);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_cmd_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_basic();
    int last_n = -1;
    int done_n = -1;
    int dcnt = 0;
    out_ready = 1'b1;
    send_cmd(16'h0100, 2, 4, 16'h0008);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_last && last_n < 0) last_n = n;
      if (done) begin
        dcnt++;
        if (done_n < 0) done_n = n;
      end
    end
    total++;
    if (last_n != 10) begin
      bad++;
      $display("FAIL basic_last_latency: got %0d cycles want 10", last_n);
    end
    total++;
    if (done_n != 11 || dcnt != 1) begin
      bad++;
      $display("FAIL basic_done: got cycle=%0d pulses=%0d want cycle=11 pulses=1", done_n, dcnt);
    end
    total++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_drain: got pending=%0d busy=%b want pending=0 busy=0", sb.size(), busy);
    end
  endtask

  task automatic test_backpressure();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] prev_addr;
    int issued = 0;
    int consumed = 0;
    int max_ahead = 0;
    int dcnt = 0;
    out_ready = 1'b1;
    prev_addr = mem_addr;
    send_cmd(16'h0100, 2, 4, 16'h0008);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (busy && mem_addr !== prev_addr) issued++;
      prev_addr = mem_addr;
      if (out_valid && out_ready) consumed++;
      if (issued - consumed > max_ahead) max_ahead = issued - consumed;
      if (done) dcnt++;
      @(posedge clk);
      #1 out_ready = pat[k % 4];
    end
    out_ready = 1'b1;
    total++;
    if (max_ahead > 2) begin
      bad++;
      $display("FAIL bp_lookahead: got %0d reads ahead want <=2", max_ahead);
    end
    total++;
    if (issued != 8 || consumed != 8) begin
      bad++;
      $display("FAIL bp_counts: got issued=%0d consumed=%0d want 8/8", issued, consumed);
    end
    total++;
    if (dcnt != 1 || sb.size() != 0) begin
      bad++;
      $display("FAIL bp_done: got pulses=%0d pending=%0d want 1/0", dcnt, sb.size());
    end
  endtask

  task automatic test_wrap();
    logic [15:0] seen [4];
    logic [15:0] prev_addr;
    int idx = 0;
    int dcnt = 0;
    out_ready = 1'b1;
    prev_addr = mem_addr;
    send_cmd(16'hFFFE, 1, 4, 16'h0000);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (busy && mem_addr !== prev_addr) begin
        if (idx < 4) seen[idx] = mem_addr;
        idx++;
      end
      prev_addr = mem_addr;
      if (done) dcnt++;
    end
    total++;
    if (idx != 4 || seen[0] !== 16'hFFFE || seen[1] !== 16'hFFFF ||
        seen[2] !== 16'h0000 || seen[3] !== 16'h0001) begin
      bad++;
      $display("FAIL wrap_addrs: got n=%0d %h %h %h %h want 4 fffe ffff 0000 0001",
               idx, seen[0], seen[1], seen[2], seen[3]);
    end
    total++;
    if (dcnt != 1 || sb.size() != 0) begin
      bad++;
      $display("FAIL wrap_done: got pulses=%0d pending=%0d want 1/0", dcnt, sb.size());
    end
  endtask

  task automatic test_zero_dim();
    int vcnt = 0;
    int dcnt = 0;
    int bcnt = 0;
    send_cmd(16'h0300, 0, 5, 16'h0001);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    total++;
    if (vcnt != 0 || bcnt != 0) begin
      bad++;
      $display("FAIL zero_quiet: got valid_cycles=%0d busy_cycles=%0d want 0/0", vcnt, bcnt);
    end
    total++;
    if (dcnt != 1 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL zero_done: got pulses=%0d cmd_ready=%b want 1/1", dcnt, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_tile();
    int hs = 0;
    int n = 0;
    int dcnt = 0;
    int bytes = 0;
    out_ready = 1'b1;
    send_cmd(16'h0200, 3, 3, 16'h0010);
    while (hs < 3 && n < 30) begin
      @(negedge clk);
      n++;
      if (out_valid && out_ready) hs++;
    end
    total++;
    if (hs != 3) begin
      bad++;
      $display("FAIL abort_reach: got %0d handshakes want 3", hs);
    end
    #1 rst = 1'b0;
    sb.delete();
    #1;
    total++;
    if ({out_valid, out_eol, out_last, busy, done, cmd_ready, mem_wen} !== 7'd0 ||
        out_data !== 8'h00 || mem_addr !== 16'h0000) begin
      bad++;
      $display("FAIL abort_outputs: got valid=%b eol=%b last=%b busy=%b done=%b rdy=%b wen=%b data=%h addr=%h want all 0",
               out_valid, out_eol, out_last, busy, done, cmd_ready, mem_wen, out_data, mem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    send_cmd(16'h0400, 1, 2, 16'h0001);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) bytes++;
      if (done) dcnt++;
    end
    total++;
    if (bytes != 2 || dcnt != 1 || sb.size() != 0) begin
      bad++;
      $display("FAIL after_abort: got bytes=%0d pulses=%0d pending=%0d want 2/1/0", bytes, dcnt, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int acc1 = -1;
    int acc2 = -1;
    int done1 = -1;
    int dcnt = 0;
    int busy_bad = 0;
    logic drop = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    while (cmd_ready !== 1'b1) @(negedge clk);
    cmd_base   = 16'h0100;
    cmd_rows   = 8'd1;
    cmd_cols   = 8'd3;
    cmd_stride = 16'h0000;
    push_tile(16'h0100, 1, 3, 16'h0000);
    push_tile(16'h0100, 1, 3, 16'h0000);
    cmd_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (cmd_valid && cmd_ready) begin
        acc++;
        if (acc == 1) acc1 = k;
        else if (acc == 2) begin
          acc2 = k;
          drop = 1'b1;
        end
      end
      if (done) begin
        dcnt++;
        if (done1 < 0) done1 = k;
        if (busy) busy_bad++;
      end
      if (drop) begin
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        drop = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    total++;
    if (acc1 != 1 || done1 != 7) begin
      bad++;
      $display("FAIL b2b_first: got accept=%0d done=%0d want 1/7", acc1, done1);
    end
    total++;
    if (acc != 2 || acc2 != done1) begin
      bad++;
      $display("FAIL b2b_second_accept: got accepts=%0d at=%0d want 2 at done cycle %0d", acc, acc2, done1);
    end
    total++;
    if (busy_bad != 0 || dcnt != 2 || sb.size() != 0) begin
      bad++;
      $display("FAIL b2b_done: got busy_at_done=%0d pulses=%0d pending=%0d want 0/2/0", busy_bad, dcnt, sb.size());
    end
    total++;
    if (wen_hits != 0) begin
      bad++;
      $display("FAIL mem_wen: got %0d cycles with wen=1 want 0", wen_hits);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) smem[i] = 8'(i * 37 + 5);
    for (int i = 0; i < 16; i++) smem[16'h0100 + i] = 8'(8'h10 + i);
    smem[16'hFFFE] = 8'hA0;
    smem[16'hFFFF] = 8'hA1;
    smem[16'h0000] = 8'hA2;
    smem[16'h0001] = 8'hA3;

    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_dim();
    test_reset_mid_tile();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
